// File: rtl/capture_window_ctrl.sv
// capture_window_ctrl: logic-analyzer capture sequencer (arm, pre-trigger fill, trigger wait, post-trigger fill, stop)
// Ports: clk/rst_n (async active-low reset); sample_en, arm, abort, trig capture controls;
// wr_en/reg_addr/reg_in/reg_out register file (0 PRE_LEN, 1 POST_LEN, 2 trig_addr, 3 total_cnt);
// buf_we/buf_addr circular sample buffer write port; busy, done, trig_addr status.
module capture_window_ctrl #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  input  logic                wr_en,
  input  logic [1:0]          reg_addr,
  input  logic [CNT_BITS-1:0] reg_in,
  output logic [CNT_BITS-1:0] reg_out,
  output logic                buf_we,
  output logic [CNT_BITS-1:0] buf_addr,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] trig_addr
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  localparam logic [CNT_BITS-1:0] ONE = 1;
  state_t state, state_nx;
  logic [CNT_BITS-1:0] pre_len, post_len, pre_cnt, post_cnt, total_cnt;
  logic start;
  assign busy = (state == PRE) || (state == WAIT) || (state == POST);
  assign done = state == DONE;
  assign buf_we = sample_en && busy && !abort;
  assign start = arm && !abort && (state == IDLE || state == DONE);
  assign reg_out = reg_addr == 2'd0 ? pre_len :
                   reg_addr == 2'd1 ? post_len :
                   reg_addr == 2'd2 ? trig_addr : total_cnt;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else
      case (state)
        IDLE, DONE: if (arm) state_nx = pre_len == '0 ? WAIT : PRE;
        PRE:        if (sample_en && pre_cnt + ONE == pre_len) state_nx = WAIT;
        WAIT:       if (sample_en && trig) state_nx = post_len == '0 ? DONE : POST;
        POST:       if (sample_en && post_cnt + ONE == post_len) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_len   <= '0;
      post_len  <= '0;
      trig_addr <= '0;
      buf_addr  <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      total_cnt <= '0;
    end else begin
      state <= state_nx;
      if (wr_en && !busy && reg_addr == 2'd0) pre_len <= reg_in;
      if (wr_en && !busy && reg_addr == 2'd1) post_len <= reg_in;
      if (start) begin
        buf_addr  <= '0;
        total_cnt <= '0;
        pre_cnt   <= '0;
        post_cnt  <= '0;
      end else if (buf_we) begin
        buf_addr  <= buf_addr + ONE;
        total_cnt <= total_cnt + ONE;
        if (state == PRE) pre_cnt <= pre_cnt + ONE;
        if (state == POST) post_cnt <= post_cnt + ONE;
        if (state == WAIT && trig) trig_addr <= buf_addr;
      end
    end
  end
endmodule
